// File: rtl/altivec_issue_pkg.sv
// Shared types and default sizing for the AltiVec issue controller slice.
package altivec_issue_pkg;

    localparam int DEF_DW      = 128;
    localparam int DEF_OPW     = 8;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_OPW-1:0] op;
        logic [DEF_DW-1:0]  va;
        logic [DEF_DW-1:0]  vb;
        logic [DEF_DW-1:0]  vc;
    } req_t;

endpackage

// File: rtl/altivec_issue_ctrl_if.sv
// Request, vsfx/pu issue and response signals of the issue controller.
interface altivec_issue_ctrl_if
    import altivec_issue_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int OPW = DEF_OPW
) ();

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [DW-1:0]  in_va;
    logic [DW-1:0]  in_vb;
    logic [DW-1:0]  in_vc;

    logic           go1;
    logic           go2;
    logic           go3;
    logic [OPW-1:0] dut_op;
    logic [DW-1:0]  dut_va;
    logic [DW-1:0]  dut_vb;
    logic [DW-1:0]  dut_vc;
    logic           dut_busy;
    logic           dut_done;
    logic [DW-1:0]  dut_vd;

    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_vd;
    logic           out_err;

    // Controller side.
    modport slave (
        input  in_valid, in_op, in_va, in_vb, in_vc,
        input  dut_busy, dut_done, dut_vd,
        input  out_ready,
        output in_ready,
        output go1, go2, go3, dut_op, dut_va, dut_vb, dut_vc,
        output out_valid, out_vd, out_err
    );

    // Requester / execution-unit side.
    modport master (
        output in_valid, in_op, in_va, in_vb, in_vc,
        output dut_busy, dut_done, dut_vd,
        output out_ready,
        input  in_ready,
        input  go1, go2, go3, dut_op, dut_va, dut_vb, dut_vc,
        input  out_valid, out_vd, out_err
    );

endinterface

// File: rtl/altivec_issue_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two, at least 2.
module altivec_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/altivec_issue_ctrl.sv
// Queues vector requests, issues them one at a time to vsfx/pu, waits for
// completion (or times out) and holds the result until it is consumed.
module altivec_issue_ctrl
    import altivec_issue_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int OPW     = DEF_OPW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    altivec_issue_ctrl_if.slave  bus
);

    localparam int RW = OPW + 3 * DW;

    state_t          state;
    logic [15:0]     wait_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [RW-1:0]   head;

    logic            go_r;
    logic [OPW-1:0]  op_r;
    logic [DW-1:0]   va_r;
    logic [DW-1:0]   vb_r;
    logic [DW-1:0]   vc_r;
    logic            out_valid_r;
    logic [DW-1:0]   out_vd_r;
    logic            out_err_r;

    assign bus.in_ready = !fifo_full;
    assign fifo_pop     = (state == ISSUE);

    altivec_issue_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid && !fifo_full),
        .wdata ({bus.in_op, bus.in_va, bus.in_vb, bus.in_vc}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue outputs are loaded on the IDLE->ISSUE edge, so they are valid for
    // exactly the ISSUE cycle and zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            go_r        <= 1'b0;
            op_r        <= '0;
            va_r        <= '0;
            vb_r        <= '0;
            vc_r        <= '0;
            out_valid_r <= 1'b0;
            out_vd_r    <= '0;
            out_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && !bus.dut_busy) begin
                        state <= ISSUE;
                        go_r  <= 1'b1;
                        op_r  <= head[RW-1 -: OPW];
                        va_r  <= head[3*DW-1 -: DW];
                        vb_r  <= head[2*DW-1 -: DW];
                        vc_r  <= head[DW-1:0];
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    go_r     <= 1'b0;
                    op_r     <= '0;
                    va_r     <= '0;
                    vb_r     <= '0;
                    vc_r     <= '0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // A completion in the final counted cycle still wins.
                    if (bus.dut_done) begin
                        state       <= RESP;
                        out_valid_r <= 1'b1;
                        out_vd_r    <= bus.dut_vd;
                        out_err_r   <= 1'b0;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        out_valid_r <= 1'b1;
                        out_vd_r    <= '0;
                        out_err_r   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.go1       = go_r;
    assign bus.go2       = go_r;
    assign bus.go3       = go_r;
    assign bus.dut_op    = op_r;
    assign bus.dut_va    = va_r;
    assign bus.dut_vb    = vb_r;
    assign bus.dut_vc    = vc_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_vd    = out_vd_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: doc/altivec_issue_ctrl.md
ALTIVEC_ISSUE_CTRL -- requirements
Module: altivec_issue_ctrl

Interface
REQ-001 SHALL have parameter DW, default 128, meaning vector operand/result width.
REQ-002 SHALL have parameter OPW, default 8, meaning opcode width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning request FIFO entries (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 64, meaning max WAIT cycles before abort.
REQ-005 Ports, in this order, one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_op  in  OPW  opcode
- in_va, in_vb, in_vc  in  DW each  source operands
- go1, go2, go3  out  1 each  issue strobes to vsfx/pu
- dut_op  out  OPW  opcode to vsfx/pu
- dut_va, dut_vb, dut_vc  out  DW each  operands to vsfx/pu
- dut_busy  in  1  vsfx/pu busy
- dut_done  in  1  one-cycle completion pulse
- dut_vd  in  DW  result, valid with dut_done
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid&&out_ready
- out_vd  out  DW  result
- out_err  out  1  1 = timeout abort

Function
REQ-006 in_ready SHALL equal !fifo_full; accepted requests SHALL be written to the FIFO tail the same edge.
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE->ISSUE SHALL occur when the FIFO is non-empty and dut_busy==0; otherwise IDLE holds.
REQ-009 In ISSUE, go1, go2, go3 SHALL all be 1 for exactly one cycle, with dut_op/dut_va/dut_vb/dut_vc driven from the FIFO head; the head SHALL be popped at that edge; next state WAIT.
REQ-010 go1/go2/go3 SHALL never be asserted individually or outside ISSUE; dut_* data outputs SHALL be 0 outside ISSUE.
REQ-011 vsfx/pu contract: dut_busy is 1 in every cycle where go1&&go2&&go3.
REQ-012 In WAIT, a 16-bit counter SHALL increment each cycle from 0; on dut_done, out_vd<=dut_vd, out_err<=0, next RESP.
REQ-013 If the counter reaches TIMEOUT-1 without dut_done, out_vd<=0, out_err<=1, next RESP; dut_done in that same cycle SHALL take priority (normal completion).
REQ-014 dut_done outside WAIT SHALL be ignored.
REQ-015 In RESP, out_valid SHALL be 1 and out_vd/out_err stable until out_ready; on the handshake, next IDLE.
REQ-016 Push and pop in the same cycle SHALL be supported when not full; pointers SHALL wrap modulo DEPTH; FIFO SHALL preserve order.
REQ-017 Minimum latency: request accepted at edge N, go at cycle N+2 (IDLE at N+1), given dut_busy==0 and the FSM idle.

Reset
REQ-018 While rst==1 at a clock edge: state<=IDLE, FIFO pointers/count<=0, counter<=0, out_vd<=0, out_err<=0.
REQ-019 Reset values of outputs: in_ready=1 after reset, go1/go2/go3=0, dut_*=0, out_valid=0, out_vd=0, out_err=0.
REQ-020 rst asserted mid-operation (ISSUE/WAIT/RESP) SHALL discard the in-flight request and all queued entries; no go strobe in the cycle after the reset edge.

Structure
REQ-021 Package altivec_issue_pkg SHALL hold the state enum typedef, the default DW/OPW/DEPTH/TIMEOUT constants, and the request struct (op, va, vb, vc).
REQ-022 The FIFO SHALL be sub-module altivec_issue_fifo (sync, parameterized width/depth, full/empty flags); the FSM SHALL live in altivec_issue_ctrl.

Verification
REQ-023 The bench SHALL bind the existing busy assertion (go1&&go2&&go3 |-> dut_busy) and assert REQ-010 throughout.
REQ-024 Single op: op=0x04, va=1, vb=2, vc=0, DUT done after 3 cycles with vd=3 -> go strobes once at N+2, out_valid with out_vd=3, out_err=0.
REQ-025 Back-to-back: 3 requests with DEPTH=2 and dut_busy held high -> third request stalls (in_ready=0); responses emerge in order.
REQ-026 Timeout: TIMEOUT=8, DUT never pulses done -> out_valid after 8 WAIT cycles with out_err=1, out_vd=0; next request issues normally.
REQ-027 Backpressure: out_ready=0 for 5 cycles in RESP -> out_vd/out_err stable, no new go until the handshake.
REQ-028 Reset in WAIT with 1 entry queued -> all outputs at reset values, in_ready=1, late dut_done ignored, no go until a new request.
